// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, unsigned or two's-complement
//
// Computes Quotient and Remainder of A / B, one quotient bit per clock, with a
// start/busy/done handshake. Signed results truncate toward zero; the remainder
// takes the dividend's sign.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          request, accepted only in IDLE
//   Signed         1 = two's-complement divide, 0 = unsigned
//   A, B           dividend, divisor (latched on the accepting edge)
//   busy           high in CALC, FIX and DONE
//   done           one-cycle pulse, results valid from this cycle
//   Quotient       quotient, held until the next result
//   Remainder      remainder, held until the next result
//   DivByZeroFlag  B == 0 for the last operation
//   OverflowFlag   signed most-negative / -1 for the last operation

module seq_divider #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  Signed,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] Quotient,
  output logic [data_width-1:0] Remainder,
  output logic                  DivByZeroFlag,
  output logic                  OverflowFlag
);

  localparam int W  = data_width;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  rem_q, rem_d;       // partial remainder
  logic [W-1:0]  quo_q, quo_d;       // dividend shifting out / quotient shifting in
  logic [W-1:0]  dvsr_q, dvsr_d;     // |B|
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic          ovf_q, ovf_d;       // overflow detected at accept, published at FIX
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  remo_q, remo_d;
  logic          dbz_q, dbz_d;
  logic          ovff_q, ovff_d;

  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    trial;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      ovff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      ovff_q  <= ovff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ovff_d  = ovff_q;

    a_mag = (Signed && A[W-1]) ? (~A + ONE) : A;
    b_mag = (Signed && B[W-1]) ? (~B + ONE) : B;
    // Shifted remainder with the next dividend bit, one bit wider so the
    // borrow shows up in the MSB.
    trial = {rem_q, quo_q[W-1]} - {1'b0, dvsr_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d  = 1'b0;
          ovff_d = 1'b0;
          if (B == '0) begin
            quot_d  = '1;
            remo_d  = A;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvsr_d  = b_mag;
            q_neg_d = Signed & (A[W-1] ^ B[W-1]);
            r_neg_d = Signed & A[W-1];
            ovf_d   = Signed && (A == MOST_NEG) && (B == '1);
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // No borrow: keep the difference. Its top bit is dropped safely because
        // the difference is always smaller than the divisor.
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[W-2:0], quo_q[W-1]};
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // Overflow needs no special case: |MOST_NEG| / 1 yields MOST_NEG with a
        // positive sign, which is already the wrapped result.
        quot_d  = q_neg_q ? (~quo_q + ONE) : quo_q;
        remo_d  = r_neg_q ? (~rem_q + ONE) : rem_q;
        ovff_d  = ovf_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign Quotient      = quot_q;
  assign Remainder     = remo_q;
  assign DivByZeroFlag = dbz_q;
  assign OverflowFlag  = ovff_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider

module tb_seq_divider;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        Signed;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        DivByZeroFlag;
  logic        OverflowFlag;

  int n_tests;
  int n_fail;

  seq_divider #(.data_width(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .Signed        (Signed),
    .A             (A),
    .B             (B),
    .busy          (busy),
    .done          (done),
    .Quotient      (Quotient),
    .Remainder     (Remainder),
    .DivByZeroFlag (DivByZeroFlag),
    .OverflowFlag  (OverflowFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request before an edge and return just after the accepting edge.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start  = 1'b1;
    Signed = s;
    A      = a;
    B      = b;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; lat counts that edge as 1.
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 100) check("done_timeout", 32'(lat), 32'd0);
  endtask

  // One complete operation; operands are scrambled after accept to prove latching.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input logic eov, input int elat);
    int lat;
    issue(s, a, b);
    #1;
    start  = 1'b0;
    A      = ~a;
    B      = b + 16'd3;
    Signed = ~s;
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, 32'(Quotient), 32'(eq));
    check({tag, "_r"}, 32'(Remainder), 32'(er));
    check({tag, "_dz"}, 32'(DivByZeroFlag), 32'(edz));
    check({tag, "_ov"}, 32'(OverflowFlag), 32'(eov));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int seen_done;
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    Signed  = 1'b0;
    A       = '0;
    B       = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(Quotient), 32'd0);
    check("rst_r", 32'(Remainder), 32'd0);
    check("rst_dz", 32'(DivByZeroFlag), 32'd0);
    check("rst_ov", 32'(OverflowFlag), 32'd0);
    reset_n = 1'b1;

    run_op("u100_7",  1'b0, 16'd100,  16'd7,      16'd14,    16'd2,     1'b0, 1'b0, 18);
    run_op("s-7_2",   1'b1, 16'hFFF9, 16'h0002,   16'hFFFD,  16'hFFFF,  1'b0, 1'b0, 18);
    run_op("s7_-2",   1'b1, 16'h0007, 16'hFFFE,   16'hFFFD,  16'h0001,  1'b0, 1'b0, 18);
    run_op("s-100_-7",1'b1, 16'hFF9C, 16'hFFF9,   16'd14,    16'hFFFE,  1'b0, 1'b0, 18);
    run_op("dbz",     1'b0, 16'h1234, 16'h0000,   16'hFFFF,  16'h1234,  1'b1, 1'b0, 1);
    run_op("s_ovf",   1'b1, 16'h8000, 16'hFFFF,   16'h8000,  16'h0000,  1'b0, 1'b1, 18);
    run_op("u_noovf", 1'b0, 16'h8000, 16'hFFFF,   16'h0000,  16'h8000,  1'b0, 1'b0, 18);
    run_op("u_big",   1'b0, 16'hFFFF, 16'h00FF,   16'h0101,  16'h0000,  1'b0, 1'b0, 18);

    // start pulsed during CALC must be ignored, not queued.
    issue(1'b0, 16'd1000, 16'd10);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    A     = 16'd5;
    B     = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_q", 32'(Quotient), 32'd100);
    check("ign_r", 32'(Remainder), 32'd0);
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) seen_done++;
    end
    check("ign_not_queued", 32'(seen_done), 32'd0);

    // start held high: back-to-back operations, one IDLE cycle between.
    issue(1'b0, 16'd50, 16'd5);
    wait_done(lat);
    check("b2b1_q", 32'(Quotient), 32'd10);
    check("b2b1_r", 32'(Remainder), 32'd0);
    A = 16'd9;
    B = 16'd4;
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("b2b2_accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat);
    check("b2b2_q", 32'(Quotient), 32'd2);
    check("b2b2_r", 32'(Remainder), 32'd1);
    @(negedge clk);
    check("b2b2_pulse", 32'(done), 32'd0);

    // Asynchronous reset in the middle of CALC.
    issue(1'b0, 16'd1000, 16'd3);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_q", 32'(Quotient), 32'd0);
    check("mid_rst_r", 32'(Remainder), 32'd0);
    check("mid_rst_dz", 32'(DivByZeroFlag), 32'd0);
    check("mid_rst_ov", 32'(OverflowFlag), 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("mid_rst_no_done", 32'(seen_done), 32'd0);
    run_op("post_rst", 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
